// File: rtl/sipo_ctrl_pkg.sv
// Shared types and line levels for the serial framing controller.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/sipo_shift.sv
// MSB-first serial-in/parallel-out shift register; the earliest bit ends in q[WIDTH-1].
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (shift_en)
            q <= {q[WIDTH-2:0], d};
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start/data/stop framing FSM around sipo_shift with a valid/ready output
// register and sticky overrun / framing-error flags.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             en,
    input  logic             ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] sr;
    logic            shift_en;
    logic            stop_edge;
    logic            good;
    logic            out_free;
    logic            load;
    logic            ovr_set;
    logic            fe_set;

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .d        (d),
        .q        (sr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        stop_edge = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && d == START_LVL) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (en) begin
                    shift_en = 1'b1;
                    // Counter wraps to 0 on the last data bit so it never exceeds WIDTH-1.
                    if (cnt == CNT_MAX) begin
                        state_nxt = STOP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (en) begin
                    stop_edge = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A consumer taking the current word on this edge frees the slot for the new one.
    assign good     = stop_edge && (d == STOP_LVL);
    assign out_free = !valid || ready;
    assign load     = good && out_free;
    assign ovr_set  = good && !out_free;
    assign fe_set   = stop_edge && (d != STOP_LVL);

    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (load) begin
                q     <= sr;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
            if (fe_set)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4) with a queue-based frame model.
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         d = 1'b0;
    logic         en = 1'b0;
    logic         ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] q;
    logic         valid, busy, overrun, frame_err;

    int checks = 0;
    int failures = 0;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .en        (en),
        .ready     (ready),
        .clr_err   (clr_err),
        .q         (q),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Model: a frame is the list of strobed bits since the start bit; it
    // completes once start + W data + stop bits have been collected.
    logic         mbits[$];
    logic [W-1:0] mq = '0;
    logic         mvalid = 1'b0, movr = 1'b0, mferr = 1'b0;
    bit           started = 0;

    always @(posedge clk) begin
        logic         ld, oset, fset;
        logic [W-1:0] word;
        if (reset) begin
            mbits.delete();
            mq = '0; mvalid = 0; movr = 0; mferr = 0;
            started = 1;
        end else begin
            ld = 0; oset = 0; fset = 0; word = '0;
            if (en) begin
                if (mbits.size() == 0) begin
                    if (d) mbits.push_back(d);
                end else begin
                    mbits.push_back(d);
                    if (mbits.size() == W + 2) begin
                        for (int i = 0; i < W; i++) word[W-1-i] = mbits[1+i];
                        if (d) fset = 1;
                        else if (!mvalid || ready) ld = 1;
                        else oset = 1;
                        mbits.delete();
                    end
                end
            end
            if (ld) begin mq = word; mvalid = 1; end
            else if (mvalid && ready) mvalid = 0;
            if (oset) movr = 1; else if (clr_err) movr = 0;
            if (fset) mferr = 1; else if (clr_err) mferr = 0;
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (started) begin
            cmp("q", q, mq);
            cmp("valid", W'(valid), W'(mvalid));
            cmp("busy", W'(busy), W'(mbits.size() != 0));
            cmp("overrun", W'(overrun), W'(movr));
            cmp("frame_err", W'(frame_err), W'(mferr));
        end
    end

    // Literal expectation, checked against both the DUT and the model.
    task automatic lit(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] mdl, input logic [W-1:0] exp);
        cmp({name, "_dut"}, act, exp);
        cmp({name, "_model"}, mdl, exp);
    endtask

    task automatic cyc(input logic dd, input logic ee);
        d = dd; en = ee;
        @(negedge clk);
    endtask

    task automatic strobe(input logic dd, input int gap);
        cyc(dd, 1'b1);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] w, input logic stop, input int gap,
                        input logic rdy_on_stop);
        strobe(1'b1, gap);
        for (int i = W - 1; i >= 0; i--) strobe(w[i], gap);
        ready = rdy_on_stop;
        strobe(stop, 0);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        lit("rst_q", q, mq, 4'h0);
        lit("rst_valid", W'(valid), W'(mvalid), 4'h0);
        lit("rst_busy", W'(busy), W'(mbits.size() != 0), 4'h0);

        // Basic frame, then a one-cycle consume.
        send(4'b1011, 1'b0, 0, 1'b0);
        lit("basic_q", q, mq, 4'b1011);
        lit("basic_valid", W'(valid), W'(mvalid), 4'h1);
        ready = 1'b1; cyc(1'b0, 1'b1); ready = 1'b0;
        lit("consume_valid", W'(valid), W'(mvalid), 4'h0);
        lit("consume_q", q, mq, 4'b1011);

        // Idle line.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        lit("idle_busy", W'(busy), W'(mbits.size() != 0), 4'h0);
        lit("idle_flags", {2'b0, overrun, frame_err}, {2'b0, movr, mferr}, 4'h0);

        // Overrun: second good frame finds the output full.
        send(4'b1011, 1'b0, 0, 1'b0);
        send(4'b0110, 1'b0, 0, 1'b0);
        lit("ovr_q", q, mq, 4'b1011);
        lit("ovr_flag", W'(overrun), W'(movr), 4'h1);
        clr_err = 1'b1; cyc(1'b0, 1'b1); clr_err = 1'b0;
        lit("ovr_clr", W'(overrun), W'(movr), 4'h0);

        // Framing error from a clean reset.
        do_reset();
        send(4'b0101, 1'b1, 0, 1'b0);
        lit("fe_flag", W'(frame_err), W'(mferr), 4'h1);
        lit("fe_valid", W'(valid), W'(mvalid), 4'h0);
        lit("fe_q", q, mq, 4'h0);
        clr_err = 1'b1; cyc(1'b0, 1'b0); clr_err = 1'b0;

        // Strobe gaps, then a frame whose stop edge coincides with a consume.
        send(4'b1011, 1'b0, 1, 1'b0);
        lit("gap_q", q, mq, 4'b1011);
        lit("gap_valid", W'(valid), W'(mvalid), 4'h1);
        send(4'b0110, 1'b0, 0, 1'b1);
        lit("coinc_q", q, mq, 4'b0110);
        lit("coinc_valid", W'(valid), W'(mvalid), 4'h1);
        lit("coinc_ovr", W'(overrun), W'(movr), 4'h0);

        // Reset mid-frame, then a clean frame.
        strobe(1'b1, 0); strobe(1'b1, 0); strobe(1'b0, 0);
        reset = 1'b1; cyc(1'b1, 1'b1); reset = 1'b0;
        lit("mid_q", q, mq, 4'h0);
        lit("mid_outs", {valid, busy, overrun, frame_err},
            {mvalid, logic'(mbits.size() != 0), movr, mferr}, 4'h0);
        send(4'b1001, 1'b0, 0, 1'b0);
        lit("after_q", q, mq, 4'b1001);
        lit("after_flags", {2'b0, overrun, frame_err}, {2'b0, movr, mferr}, 4'h0);

        cyc(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller for the serial-in/parallel-out shift path. It watches a serial line for a start bit and sequences exactly WIDTH shifts into an internal SIPO register. It checks the stop bit, then presents the assembled word on a valid/ready output port. It sits between a raw serial input and any parallel consumer, and flags overrun and framing errors.

## Interface

- WIDTH, 4: data bits per frame; legal range ≥ 2.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; priority over every other input.
- d  input  1  serial data line; idle level 0.
- en  input  1  bit strobe; d is sampled only on edges where en=1.
- ready  input  1  consumer accepts q on edges where valid=1 and ready=1.
- clr_err  input  1  clears overrun and frame_err.
- q  output  WIDTH  last accepted word; first data bit received lands in q[WIDTH-1].
- valid  output  1  q holds an unconsumed word.
- busy  output  1  high whenever FSM is not IDLE.
- overrun  output  1  sticky; a good frame was dropped because the output was full.
- frame_err  output  1  sticky; a frame ended with stop bit = 1.

## Operation

- Reset values: q=0, valid=0, busy=0, overrun=0, frame_err=0. Reset also sets FSM=IDLE, shift register=0 and bit counter=0.
- FSM states:
  - IDLE: on en=1 and d=1 (start bit), go to DATA with cnt=0. On en=1 and d=0, stay.
  - DATA: on en=1, shift sr <= {sr[WIDTH-2:0], d} and increment cnt. When cnt==WIDTH-1 on a strobed edge, go to STOP.
  - STOP: on en=1, sample the stop bit and return to IDLE.
    - Stop bit 0 with output free: the word is good. Load q<=sr and set valid=1.
    - Stop bit 0 with output full: set overrun=1 and discard the word; q is unchanged.
    - Stop bit 1: set frame_err=1 and discard the word. valid and q are unchanged.
- The output is free when valid=0, or when valid=1 and ready=1 on the same edge. In the second case the new word loads and valid stays 1.
- valid clears on any edge with valid=1 and ready=1 where no new word loads.
- en=0 freezes FSM, cnt and sr. The output handshake still proceeds.
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- clr_err=1 clears both flags. If a flag-set event coincides with clr_err, the set wins.
- Reset mid-frame abandons the partial word silently; no flag is set.

## Timing

- With en held high and start bit sampled at edge k:
  - data bits are sampled at edges k+1 … k+WIDTH;
  - the stop bit is sampled at edge k+WIDTH+1;
  - valid is high after edge k+WIDTH+1.
- Total latency from start sample to valid is WIDTH+1 strobes.
- The shift register is one bit per strobe; there is no bubble.
- A new start bit can be sampled on the strobe immediately after the stop bit, so frames run back-to-back.
- busy rises after the start edge and falls after the stop edge. It is decoded from the state register (registered, no combinational path from d).
- The output handshake is independent of en; a word can be consumed on any edge.

## Structure

- Package sipo_ctrl_pkg holds:
  - state enum: IDLE=2'd0, DATA=2'd1, STOP=2'd2;
  - constants START_LVL=1'b1 and STOP_LVL=1'b0.
- Sub-module sipo_shift: a WIDTH-parameterised shift register with ports clk, reset, shift_en, d and q[WIDTH-1:0], MSB-first.
- sipo_frame_ctrl holds the FSM, bit counter, output register and flags.

## Test plan

All scenarios use WIDTH=4 with en=1 unless stated.

- Basic frame: after reset, drive d=1,1,0,1,1,0 (start, 1011, stop) with ready=0 → q=4'b1011 and valid=1 after the 6th edge. Raising ready for one cycle → valid=0 and q holds 1011.
- Idle line: d=0 for 20 cycles → busy stays 0, valid stays 0, no flags set.
- Overrun: two back-to-back frames 1011 then 0110 with ready=0 → q=1011, valid=1, overrun=1. Pulsing clr_err → overrun=0.
- Framing error: start, 0101, stop=1 → frame_err=1, valid=0, q=0.
- Strobe gaps and coincident handshake:
  - en high every other cycle for frame 1011 → same q; valid appears after the 11th edge.
  - ready=1 during the stop edge of the next frame 0110 → q=0110, valid stays 1.
- Reset mid-frame: assert reset after 2 data bits → all outputs 0 the next cycle. A following frame 1001 decodes to q=4'b1001 with no flags set.
